// File: rtl/seq_event_pkg.sv
// Shared definitions for the per-channel event sequencer: channel state
// encoding and the wrap/sticky mode constants.
package seq_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        TERM  = 2'b10
    } state_e;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_STICKY = 1'b1;

endpackage

// File: rtl/seq_event_if.sv
// Control/status bundle for seq_event_fsm. The live count bus exists only
// when SEQ_EVENT_CNT_OUT_EN is defined.
interface seq_event_if #(
    parameter int CNT_W  = 4,
    parameter int NUM_CH = 2
);

    logic                     en;
    logic                     mode;
    logic [CNT_W-1:0]         term;
    logic [NUM_CH-1:0]        x;
    logic [NUM_CH-1:0]        clr;
    logic [NUM_CH-1:0]        y;
    logic [NUM_CH-1:0]        done;
`ifdef SEQ_EVENT_CNT_OUT_EN
    logic [NUM_CH*CNT_W-1:0]  cnt;
`endif

    modport master (
        output en, mode, term, x, clr,
        input  y, done
`ifdef SEQ_EVENT_CNT_OUT_EN
        , input cnt
`endif
    );

    modport slave (
        input  en, mode, term, x, clr,
        output y, done
`ifdef SEQ_EVENT_CNT_OUT_EN
        , output cnt
`endif
    );

endinterface

// File: rtl/seq_event_ch.sv
// One event-counting channel: IDLE -> COUNT -> TERM, terminal count latched
// on leaving IDLE, wrap or sticky behaviour in TERM, clear beats events.
// The cnt port is present only when SEQ_EVENT_CNT_OUT_EN is defined.
module seq_event_ch
    import seq_event_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] term,
    input  logic             x,
    input  logic             clr,
    output logic             y,
    output logic             done
`ifdef SEQ_EVENT_CNT_OUT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [CNT_W-1:0] term_l, term_l_nx;
    logic             done_q, done_nx;

    // Next-state, next-count and done-pulse decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        cnt_nx    = cnt_q;
        term_l_nx = term_l;
        done_nx   = 1'b0;

        case (state)
            IDLE: begin
                // A zero terminal count keeps the channel parked here.
                if (en && x && (term != '0)) begin
                    term_l_nx = term;
                    cnt_nx    = CNT_W'(1);
                    state_nx  = (term == CNT_W'(1)) ? TERM : COUNT;
                end
            end
            COUNT: begin
                if (en && x) begin
                    cnt_nx = cnt_q + CNT_W'(1);
                    if (cnt_nx == term_l) begin
                        state_nx = TERM;
                    end
                end
            end
            TERM: begin
                if (en && x && (mode == MODE_WRAP)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean IDLE.
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Clear overrides everything, including a coincident event and en=0.
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end

        done_nx = (state_nx == TERM) && (state != TERM);
    end

    // State, count, latched terminal count and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_q  <= '0;
            term_l <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state  <= state_nx;
            cnt_q  <= cnt_nx;
            term_l <= term_l_nx;
            done_q <= done_nx;
        end
    end

    assign y    = (state == TERM);
    assign done = done_q;
`ifdef SEQ_EVENT_CNT_OUT_EN
    assign cnt  = cnt_q;
`endif

endmodule

// File: rtl/seq_event_fsm.sv
// Top level: NUM_CH independent event-counting channels sharing en, mode
// and term. Define SEQ_EVENT_CNT_OUT_EN to expose each channel's live count.
module seq_event_fsm #(
    parameter int CNT_W  = 4,
    parameter int NUM_CH = 2
) (
    input logic       clk,
    input logic       rst_n,
    seq_event_if.slave bus
);

    logic [NUM_CH-1:0]       y_w;
    logic [NUM_CH-1:0]       done_w;
`ifdef SEQ_EVENT_CNT_OUT_EN
    logic [NUM_CH*CNT_W-1:0] cnt_w;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        seq_event_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .mode  (bus.mode),
            .term  (bus.term),
            .x     (bus.x[i]),
            .clr   (bus.clr[i]),
            .y     (y_w[i]),
            .done  (done_w[i])
`ifdef SEQ_EVENT_CNT_OUT_EN
            ,
            .cnt   (cnt_w[i*CNT_W +: CNT_W])
`endif
        );
    end

    assign bus.y    = y_w;
    assign bus.done = done_w;
`ifdef SEQ_EVENT_CNT_OUT_EN
    assign bus.cnt  = cnt_w;
`endif

endmodule

// File: tb/tb_seq_event_fsm.sv
// Self-checking bench for seq_event_fsm (CNT_W=4, NUM_CH=2). A rule-level
// model predicts y/done (and cnt when SEQ_EVENT_CNT_OUT_EN is defined) and is
// compared every cycle; directed scenarios add hand-computed expectations.
module tb_seq_event_fsm;

    localparam int CNT_W  = 4;
    localparam int NUM_CH = 2;

    logic clk;
    logic rst_n;
    bit   run;
    int   total;
    int   bad;

    seq_event_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

    seq_event_fsm #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count of events seen, the terminal count captured when counting
    // started, whether the terminal count has been reached, and the pulse.
    int m_cnt  [NUM_CH] = '{default: 0};
    int m_tl   [NUM_CH] = '{default: 0};
    bit m_term [NUM_CH] = '{default: 0};
    bit m_done [NUM_CH] = '{default: 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i] = 0; m_tl[i] = 0; m_term[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                bit was;
                was = m_term[i];
                if (bus.clr[i]) begin
                    m_cnt[i] = 0; m_term[i] = 0; m_done[i] = 0;
                end else if (!bus.en) begin
                    m_done[i] = 0;
                end else begin
                    if (bus.x[i]) begin
                        if (m_term[i]) begin
                            if (bus.mode == 1'b0) begin
                                m_term[i] = 0; m_cnt[i] = 0;
                            end
                        end else if (m_cnt[i] == 0) begin
                            if (bus.term != 0) begin
                                m_tl[i]   = int'(bus.term);
                                m_cnt[i]  = 1;
                                m_term[i] = (m_tl[i] == 1);
                            end
                        end else begin
                            m_cnt[i]  = m_cnt[i] + 1;
                            m_term[i] = (m_cnt[i] == m_tl[i]);
                        end
                    end
                    m_done[i] = m_term[i] && !was;
                end
            end
        end
    end

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (run && rst_n) begin
            logic [NUM_CH-1:0] ey, ed;
            for (int i = 0; i < NUM_CH; i++) begin
                ey[i] = m_term[i];
                ed[i] = m_done[i];
            end
            check("model_y", bus.y, ey);
            check("model_done", bus.done, ed);
`ifdef SEQ_EVENT_CNT_OUT_EN
            for (int i = 0; i < NUM_CH; i++)
                check("model_cnt", bus.cnt[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
        end
    end

    // Apply one cycle of x/clr starting at a falling edge; returns at the next one.
    task automatic cyc(input logic [1:0] xv, input logic [1:0] cv);
        bus.x   = xv;
        bus.clr = cv;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; run = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.term = '0; bus.x = '0; bus.clr = '0;
        repeat (2) @(negedge clk);
        check("reset_y", bus.y, 2'b00);
        check("reset_done", bus.done, 2'b00);
        rst_n = 1'b1;
        run   = 1;

        // Reset mid-count: ch0 at 2 of 3, ch1 just entered TERM.
        bus.en = 1'b1; bus.term = 4'd3; bus.mode = 1'b0;
        cyc(2'b11, 2'b00);
        cyc(2'b11, 2'b00);
        cyc(2'b10, 2'b00);
        check("pre_rst_y", bus.y, 2'b10);
        check("pre_rst_done", bus.done, 2'b10);
`ifdef SEQ_EVENT_CNT_OUT_EN
        check("pre_rst_cnt0", bus.cnt[3:0], 4'd2);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y", bus.y, 2'b00);
        check("async_rst_done", bus.done, 2'b00);
`ifdef SEQ_EVENT_CNT_OUT_EN
        check("async_rst_cnt", bus.cnt, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap mode, non-contiguous events on ch0.
        bus.term = 4'd3; bus.mode = 1'b0;
        cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b00);
        cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b00);
        cyc(2'b00, 2'b00);
        check("wrap_pre_y", bus.y, 2'b00);
        cyc(2'b01, 2'b00);
        check("wrap_term_y", bus.y, 2'b01);
        check("wrap_term_done", bus.done, 2'b01);
        cyc(2'b00, 2'b00);
        check("wrap_hold_y", bus.y, 2'b01);
        check("wrap_hold_done", bus.done, 2'b00);
        cyc(2'b01, 2'b00);
        check("wrap_idle_y", bus.y, 2'b00);

        // Sticky mode on ch1.
        bus.term = 4'd2; bus.mode = 1'b1;
        cyc(2'b10, 2'b00);
        cyc(2'b10, 2'b00);
        check("sticky_term_y", bus.y, 2'b10);
        check("sticky_term_done", bus.done, 2'b10);
        for (int k = 0; k < 10; k++) cyc(2'b10, 2'b00);
        check("sticky_hold_y", bus.y, 2'b10);
        check("sticky_hold_done", bus.done, 2'b00);
        cyc(2'b10, 2'b10);
        check("sticky_clr_y", bus.y, 2'b00);
`ifdef SEQ_EVENT_CNT_OUT_EN
        check("sticky_clr_cnt1", bus.cnt[7:4], 4'd0);
`endif

        // Clear/event collision on ch0 at count 2: the event is dropped.
        bus.mode = 1'b0; bus.term = 4'd3;
        cyc(2'b01, 2'b00);
        cyc(2'b01, 2'b00);
        cyc(2'b01, 2'b01);
        check("coll_y", bus.y, 2'b00);
        cyc(2'b01, 2'b00);
        cyc(2'b01, 2'b00);
        check("coll_two_more_y", bus.y, 2'b00);
        cyc(2'b01, 2'b00);
        check("coll_third_y", bus.y, 2'b01);
        cyc(2'b00, 2'b01);

        // Zero terminal count disables the channel.
        bus.term = 4'd0;
        for (int k = 0; k < 5; k++) begin
            cyc(2'b01, 2'b00);
            check("term0_y", bus.y, 2'b00);
        end

        // Terminal count of one: first event goes straight to TERM.
        bus.term = 4'd1;
        cyc(2'b01, 2'b00);
        check("term1_y", bus.y, 2'b01);
        check("term1_done", bus.done, 2'b01);
        cyc(2'b01, 2'b00);
        check("term1_wrap_y", bus.y, 2'b00);

        // Terminal count is latched when counting starts.
        bus.term = 4'd3;
        cyc(2'b01, 2'b00);
        bus.term = 4'd5;
        cyc(2'b01, 2'b00);
        cyc(2'b01, 2'b00);
        check("latch_y", bus.y, 2'b01);
        check("latch_done", bus.done, 2'b01);
        cyc(2'b00, 2'b00);

        // Enable low freezes both channels (ch0 in TERM, ch1 at count 1).
        cyc(2'b10, 2'b00);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 2'b00);
            check("en0_y", bus.y, 2'b01);
            check("en0_done", bus.done, 2'b00);
        end
`ifdef SEQ_EVENT_CNT_OUT_EN
        check("en0_cnt1", bus.cnt[7:4], 4'd1);
`endif
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) cyc(2'b10, 2'b00);
        check("en1_pre_y", bus.y, 2'b01);
        cyc(2'b10, 2'b00);
        check("en1_term_y", bus.y, 2'b11);
        check("en1_term_done", bus.done, 2'b10);

        cyc(2'b00, 2'b00);
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_event_fsm.md
SEQ_EVENT_FSM -- requirements
Module: seq_event_fsm

Interface
REQ-001 Parameter CNT_W, default 4: width of the per-channel event counter and of term; legal range 2..16.
REQ-002 Parameter NUM_CH, default 2: number of independent channels; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 en  input  1  global count enable; when low, event counting is frozen.
REQ-006 mode  input  1  0 = wrap mode; 1 = sticky mode; applies to all channels.
REQ-007 term  input  CNT_W  terminal event count, shared by all channels.
REQ-008 x  input  NUM_CH  per-channel event input; each clk cycle with x[i]=1 is one event.
REQ-009 clr  input  NUM_CH  per-channel synchronous clear.
REQ-010 y  output  NUM_CH  per-channel terminal flag; Moore output, decoded from registered state only.
REQ-011 done  output  NUM_CH  per-channel registered one-cycle pulse on entry to TERM.
REQ-012 cnt  output  NUM_CH*CNT_W  per-channel event count, channel i in bits [i*CNT_W +: CNT_W]; present only when SEQ_EVENT_CNT_OUT_EN is defined.

Function
REQ-013 Each channel SHALL run its own 3-state FSM: IDLE (cnt=0), COUNT (0<cnt<term_l), TERM (y=1).
REQ-014 Each channel SHALL latch term into a private term_l on the IDLE->COUNT or IDLE->TERM transition; changes to term at any other time SHALL be ignored until the channel next leaves IDLE.
REQ-015 In IDLE or COUNT, a cycle with en=1 and x[i]=1 SHALL increment cnt; when the incremented value equals term_l, the channel SHALL enter TERM, otherwise it SHALL enter or stay in COUNT.
REQ-016 term=0 sampled in IDLE SHALL disable the channel: it stays in IDLE, cnt stays 0, and y is never asserted.
REQ-017 term=1 SHALL move the channel from IDLE to TERM on the first event.
REQ-018 Cycles with x[i]=0 SHALL hold state and cnt; events need not be contiguous.
REQ-019 In TERM, cnt SHALL hold term_l.
REQ-020 In TERM with mode=0, an event SHALL return the channel to IDLE with cnt=0; with no event it SHALL stay in TERM.
REQ-021 In TERM with mode=1, the channel SHALL stay in TERM regardless of x until clr[i] is asserted.
REQ-022 y[i] SHALL be 1 exactly while the channel is in TERM.
REQ-023 done[i] SHALL be 1 only on the first cycle y[i] is 1 after each entry to TERM.
REQ-024 clr[i]=1 SHALL force the channel to IDLE with cnt=0 at the next edge, regardless of en; when clr[i] and x[i] are both high in the same cycle, clr SHALL win and the event SHALL be dropped.
REQ-025 en=0 SHALL freeze every channel's state and cnt; done SHALL be 0 while en=0.
REQ-026 A change of mode SHALL take effect from the next edge.

Reset
REQ-027 rst_n=0 SHALL immediately place every channel in IDLE with cnt=0, term_l=0, y=0 and done=0, including mid-count and in TERM.
REQ-028 The first state update after rst_n rises SHALL occur on the next clk rising edge.

Configuration
REQ-029 With SEQ_EVENT_CNT_OUT_EN defined, the cnt port SHALL be present and carry each channel's live count.
REQ-030 Without SEQ_EVENT_CNT_OUT_EN, the cnt port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package seq_event_pkg SHALL hold the state encoding (IDLE=2'b00, COUNT=2'b01, TERM=2'b10) and the mode constants MODE_WRAP=0 and MODE_STICKY=1.
REQ-032 Sub-module seq_event_ch SHALL implement one channel; the top level SHALL instantiate NUM_CH copies in a generate loop.
REQ-033 The illegal state 2'b11 SHALL recover to IDLE on the next edge.

Verification (CNT_W=4, NUM_CH=2)
REQ-034 Reset: pulse rst_n low mid-count with cnt[0]=2 -> y=0, done=0 and cnt=0 immediately, before any clk edge.
REQ-035 Wrap: term=3, mode=0, x[0] high on 3 non-contiguous cycles -> y[0]=1 and a one-cycle done[0] after the 3rd event; 4th event -> IDLE, y[0]=0; channel 1 unaffected.
REQ-036 Sticky: term=2, mode=1, x[1] held high -> y[1]=1 after 2 events and stays 1 for 10 further events; clr[1]=1 -> IDLE and cnt=0.
REQ-037 Clear collision and term=0: clr[0] and x[0] high together at cnt=2 -> cnt=0 with no increment; term=0 with x[0] high for 5 cycles -> y[0] stays 0.
REQ-038 Term latch and enable: term changed from 3 to 5 after the 1st event -> TERM after the 3rd event; en=0 for 4 cycles with x high -> cnt and state unchanged and done=0.
